distortion_mc: RTL and testbench
================================

Name: distortion_mc

Overview:
Multi-channel, parametrised successor to the single-channel distortion block. Time-multiplexed interleaved samples (ch0, ch1, ... chN-1, ch0 ...) enter on a valid/ready stream. Each sample goes through a 3-stage pipeline: gain, clip by mode, output register. Sits between the codec deserialiser and the effects mixer on the clk_48 domain; adds per-channel enable, programmable gain and threshold, and glitch-free mode changes at frame boundaries.

Parameters:
DATA_W, 24, signed sample width
NUM_CH, 2, interleaved channels per frame (>=1)
GAIN_W, 8, unsigned gain width, fixed point Q(GAIN_W-4).4 (0x10 = 1.0)
CRUSH_BITS, 8, LSBs cleared in crush mode (< DATA_W)

Ports:
clk_48  in  1  sample-domain clock
rst  in  1  asynchronous active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  block accepts input this cycle
s_data  in  DATA_W  signed input sample
options  in  4  one-hot mode: 1000 hard clip, 0100 asymmetric, 0010 fold-back, 0001 crush; any other value = bypass
en  in  NUM_CH  per-channel enable; 0 = raw passthrough for that channel
gain  in  GAIN_W  pre-clip gain
threshold  in  DATA_W-1  unsigned clip level T
m_valid  out  1  output sample valid
m_ready  in  1  downstream accepts
m_data  out  DATA_W  signed output sample
m_chan  out  clog2(NUM_CH) (min 1)  channel index of m_data
m_last  out  1  high with channel NUM_CH-1

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_data=0, m_chan=0, m_last=0, s_ready=0 while rst=1. Pipeline valids cleared. Channel counter=0. Shadow mode=bypass, shadow gain=0x10, shadow T=0. Reset mid-frame discards in-flight samples; the next accepted sample is ch0.
- Handshake: the pipeline advances when !m_valid || m_ready. s_ready = advance (combinational from m_ready and stage valids, never from s_valid). A transfer happens when s_valid && s_ready. m_data/m_chan/m_last hold stable while m_valid && !m_ready.
- Latency: 3 cycles from accepted input to m_valid with no backpressure. Throughput is 1 sample/cycle.
- Channel counter: increments on each accepted sample and wraps from NUM_CH-1 to 0. The tag travels with the sample.
- Shadow registers: options, gain and threshold are captured only on acceptance of a ch0 sample. All channels in a frame use identical settings. en[ch] is sampled at acceptance of that sample.
- Stage 1 (gain): p = s_data * {0,gain} (signed), arithmetic shift right 4, saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Stage 2 (mode), x = stage-1 result, T = {0,threshold}:
  - hard: clamp to [-T, T].
  - asymmetric: clamp to [-(T>>>1), T].
  - fold-back: x>T -> 2T-x; x<-T -> -2T-x; else x. Compute at DATA_W+2 bits, then saturate.
  - crush: x with lower CRUSH_BITS bits cleared (rounds toward -inf).
  - bypass: x.
- When en[ch]=0 the output is the original s_data, not gained, with the same 3-cycle latency.
- T=0 in a clip mode gives output 0 (asymmetric and hard).
- Stage 3 registers the result plus m_chan and m_last.

Decomposition:
- Package distortion_pkg holds:
  - one-hot mode constants MODE_HARD/ASYM/FOLD/CRUSH
  - a mode enum
  - the function sat(value, width)
- Sub-module distortion_clip: combinational stage-2 core taking x, T and mode, returning y. Instantiated once, with the registers around it in distortion_mc.

Test Plan:
- Reset then bypass (options=0000, gain=0x10): feed ch0=1000, ch1=-1000 -> after 3 cycles m_data=1000 (m_chan=0), then -1000 (m_chan=1, m_last=1).
- Hard clip (options=1000, T=5000, gain=0x20): inputs 2000, 4000, -4000 -> 4000, 5000, -5000.
- Asymmetric/fold-back (T=5000, gain=0x10): asym input -4000 -> -2500. Fold input 7000 -> 3000. Fold input -6000 -> -4000. Fold input 8388607 with gain 0xFF -> saturated positive fold result, no wrap.
- Crush + channel enable (options=0001, en=2'b01): ch0=0x0012FF -> 0x001200; ch1=0x0012FF -> 0x0012FF untouched.
- Mode change mid-frame: switch options 1000->0100 while ch1 is accepted -> ch1 still hard-clipped; change takes effect at the next ch0.
- Backpressure and reset: hold m_ready=0 for 5 cycles with continuous s_valid -> s_ready drops, m_data stable, no samples lost or duplicated. Assert rst mid-frame -> m_valid=0 immediately; after release the first output is m_chan=0.

Source files
------------

// File: rtl/distortion_pkg.sv
// Shared definitions for the multi-channel distortion block: option encodings,
// the internal mode type and a generic signed saturation helper.
package distortion_pkg;

    // One-hot encodings of the options input
    localparam logic [3:0] MODE_HARD  = 4'b1000;
    localparam logic [3:0] MODE_ASYM  = 4'b0100;
    localparam logic [3:0] MODE_FOLD  = 4'b0010;
    localparam logic [3:0] MODE_CRUSH = 4'b0001;

    typedef enum logic [2:0] {
        MODE_E_BYPASS,
        MODE_E_HARD,
        MODE_E_ASYM,
        MODE_E_FOLD,
        MODE_E_CRUSH
    } mode_e;

    // Any value that is not exactly one of the one-hot codes means bypass
    function automatic mode_e decode_mode(input logic [3:0] opt);
        case (opt)
            MODE_HARD:  return MODE_E_HARD;
            MODE_ASYM:  return MODE_E_ASYM;
            MODE_FOLD:  return MODE_E_FOLD;
            MODE_CRUSH: return MODE_E_CRUSH;
            default:    return MODE_E_BYPASS;
        endcase
    endfunction

    // Clamp a signed value to the range of a signed number of the given width
    function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/distortion_mc_if.sv
// Sample stream bundle: input valid/ready stream and tagged output stream.
interface distortion_mc_if #(
    parameter int DATA_W = 24,
    parameter int CHW    = 1
);
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_data;
    logic [CHW-1:0]           m_chan;
    logic                     m_last;

    // Block side
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_chan, m_last
    );

    // Producer/consumer side
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_chan, m_last
    );
endinterface

// File: rtl/distortion_clip.sv
// Combinational mode stage: applies hard/asymmetric clip, fold-back or bit
// crush to a gained sample. Arithmetic is done two bits wider so that the
// fold-back reflection cannot wrap before the final saturation.
module distortion_clip
    import distortion_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int CRUSH_BITS = 8
) (
    input  logic signed [DATA_W-1:0] x_i,
    input  logic        [DATA_W-2:0] thr_i,
    input  mode_e                    mode_i,
    output logic signed [DATA_W-1:0] y_o
);
    localparam int W2 = DATA_W + 2;
    localparam logic [W2-1:0] CRUSH_MASK = ~((W2'(1) << CRUSH_BITS) - W2'(1));

    logic signed [W2-1:0] xe;
    logic signed [W2-1:0] te;
    logic signed [W2-1:0] r;

    // Select the transfer function for the current mode, then saturate
    always_comb begin
        xe = {{2{x_i[DATA_W-1]}}, x_i};
        te = {3'b000, thr_i};
        r  = xe;
        case (mode_i)
            MODE_E_HARD: begin
                if (xe > te)       r = te;
                else if (xe < -te) r = -te;
            end
            MODE_E_ASYM: begin
                if (xe > te)                r = te;
                else if (xe < -(te >>> 1))  r = -(te >>> 1);
            end
            MODE_E_FOLD: begin
                if (xe > te)       r = (te <<< 1) - xe;
                else if (xe < -te) r = -(te <<< 1) - xe;
            end
            MODE_E_CRUSH: r = xe & CRUSH_MASK;
            default:      r = xe;
        endcase
        y_o = DATA_W'(sat({{(64-W2){r[W2-1]}}, r}, DATA_W));
    end

endmodule

// File: rtl/distortion_mc.sv
// Multi-channel distortion: interleaved samples pass through gain, mode and
// output register stages. Mode/gain/threshold are latched at each ch0
// acceptance so a whole frame shares one setting; each sample carries its
// own copy of those settings down the pipe.
module distortion_mc
    import distortion_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int NUM_CH     = 2,
    parameter int GAIN_W     = 8,
    parameter int CRUSH_BITS = 8
) (
    input  logic              clk_48,
    input  logic              rst,
    distortion_mc_if.slave    bus,
    input  logic [3:0]        options,
    input  logic [NUM_CH-1:0] en,
    input  logic [GAIN_W-1:0] gain,
    input  logic [DATA_W-2:0] threshold
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW  = DATA_W + GAIN_W + 1;
    localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);

    // Channel counter and frame shadow settings
    logic [CHW-1:0]    chan_q;
    mode_e             sh_mode_q;
    logic [GAIN_W-1:0] sh_gain_q;
    logic [DATA_W-2:0] sh_thr_q;

    // Stage 1: gained sample plus the settings it will be shaped with
    logic                     s1_valid_q;
    logic signed [DATA_W-1:0] s1_x_q;
    logic signed [DATA_W-1:0] s1_raw_q;
    logic                     s1_en_q;
    logic [CHW-1:0]           s1_chan_q;
    mode_e                    s1_mode_q;
    logic [DATA_W-2:0]        s1_thr_q;

    // Stage 2: shaped (or raw) sample
    logic                     s2_valid_q;
    logic signed [DATA_W-1:0] s2_y_q;
    logic [CHW-1:0]           s2_chan_q;

    // Stage 3: output register
    logic                     m_valid_q;
    logic signed [DATA_W-1:0] m_data_q;
    logic [CHW-1:0]           m_chan_q;
    logic                     m_last_q;

    logic                     advance;
    logic                     s_ready;
    logic                     accept;
    logic                     first;
    mode_e                    eff_mode;
    logic [GAIN_W-1:0]        eff_gain;
    logic [DATA_W-2:0]        eff_thr;
    logic signed [PW-1:0]     a_ext;
    logic signed [PW-1:0]     b_ext;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     sh;
    logic signed [DATA_W-1:0] gained;
    logic signed [DATA_W-1:0] clip_y;

    // Handshake: the whole pipe moves together whenever the output slot frees
    always_comb begin
        advance = !m_valid_q || bus.m_ready;
        s_ready = advance && !rst;
        accept  = bus.s_valid && s_ready;
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_chan  = m_chan_q;
    assign bus.m_last  = m_last_q;

    // A ch0 sample uses the live settings (which it also latches); later
    // channels use the frame shadow
    always_comb begin
        first    = (chan_q == '0);
        eff_mode = first ? decode_mode(options) : sh_mode_q;
        eff_gain = first ? gain : sh_gain_q;
        eff_thr  = first ? threshold : sh_thr_q;
    end

    // Gain: signed multiply by unsigned Q.4 gain, shift out the fraction, saturate
    always_comb begin
        a_ext  = {{(GAIN_W+1){bus.s_data[DATA_W-1]}}, bus.s_data};
        b_ext  = {{DATA_W{1'b0}}, 1'b0, eff_gain};
        prod   = a_ext * b_ext;
        sh     = prod >>> 4;
        gained = DATA_W'(sat({{(64-PW){sh[PW-1]}}, sh}, DATA_W));
    end

    distortion_clip #(
        .DATA_W     (DATA_W),
        .CRUSH_BITS (CRUSH_BITS)
    ) u_clip (
        .x_i    (s1_x_q),
        .thr_i  (s1_thr_q),
        .mode_i (s1_mode_q),
        .y_o    (clip_y)
    );

    // Channel counter and frame shadow capture on accepted samples
    always_ff @(posedge clk_48 or posedge rst) begin
        if (rst) begin
            chan_q    <= '0;
            sh_mode_q <= MODE_E_BYPASS;
            sh_gain_q <= GAIN_W'(16);
            sh_thr_q  <= '0;
        end else if (accept) begin
            chan_q <= (chan_q == LAST_CH) ? '0 : chan_q + CHW'(1);
            if (first) begin
                sh_mode_q <= eff_mode;
                sh_gain_q <= eff_gain;
                sh_thr_q  <= eff_thr;
            end
        end
    end

    // Three pipeline stages, all gated by the common advance
    always_ff @(posedge clk_48 or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_raw_q   <= '0;
            s1_en_q    <= 1'b0;
            s1_chan_q  <= '0;
            s1_mode_q  <= MODE_E_BYPASS;
            s1_thr_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_y_q     <= '0;
            s2_chan_q  <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_chan_q   <= '0;
            m_last_q   <= 1'b0;
        end else if (advance) begin
            s1_valid_q <= accept;
            s1_x_q     <= gained;
            s1_raw_q   <= bus.s_data;
            s1_en_q    <= en[chan_q];
            s1_chan_q  <= chan_q;
            s1_mode_q  <= eff_mode;
            s1_thr_q   <= eff_thr;
            s2_valid_q <= s1_valid_q;
            s2_y_q     <= s1_en_q ? clip_y : s1_raw_q;
            s2_chan_q  <= s1_chan_q;
            m_valid_q  <= s2_valid_q;
            m_data_q   <= s2_y_q;
            m_chan_q   <= s2_chan_q;
            m_last_q   <= (s2_chan_q == LAST_CH);
        end
    end

endmodule

// File: tb/tb_distortion_mc.sv
// Bench for distortion_mc (2 channels, 24-bit): directed frames, an arithmetic
// reference model fed at acceptance, and literal checks of collected outputs.
module tb_distortion_mc;
    localparam int  DW   = 24;
    localparam longint SMAX = 64'sd8388607;
    localparam longint SMIN = -64'sd8388608;

    logic        clk_48 = 1'b0;
    logic        rst    = 1'b1;
    logic [3:0]  options;
    logic [1:0]  en;
    logic [7:0]  gain;
    logic [22:0] threshold;

    always #5 clk_48 = ~clk_48;

    distortion_mc_if #(.DATA_W(DW), .CHW(1)) bus ();

    distortion_mc #(
        .DATA_W     (DW),
        .NUM_CH     (2),
        .GAIN_W     (8),
        .CRUSH_BITS (8)
    ) dut (
        .clk_48    (clk_48),
        .rst       (rst),
        .bus       (bus),
        .options   (options),
        .en        (en),
        .gain      (gain),
        .threshold (threshold)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference: what one sample must become under the given frame settings
    function automatic longint model(input longint s, input logic [3:0] opt,
                                     input longint g, input longint t, input logic e);
        longint x;
        if (!e) return s;
        x = clamp((s * g) >>> 4, SMIN, SMAX);
        case (opt)
            4'b1000: x = clamp(x, -t, t);
            4'b0100: x = clamp(x, -(t / 2), t);
            4'b0010: begin
                if (x > t)       x = 2 * t - x;
                else if (x < -t) x = -2 * t - x;
                x = clamp(x, SMIN, SMAX);
            end
            4'b0001: x = x - (((x % 256) + 256) % 256);
            default: ;
        endcase
        return x;
    endfunction

    longint     exp_d[$];
    int         exp_c[$];
    longint     got_d[$];
    int         got_c[$];
    int         mch;
    logic [3:0] sh_opt;
    longint     sh_g;
    longint     sh_t;
    logic       hold;
    longint     hold_d;
    int         hold_c;

    // Single compare/model process, evaluated mid-cycle
    always @(negedge clk_48) begin
        longint ed;
        int ec;
        if (rst) begin
            exp_d.delete();
            exp_c.delete();
            mch    = 0;
            sh_opt = 4'b0000;
            sh_g   = 16;
            sh_t   = 0;
            hold   = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_data", bus.m_data, hold_d);
                chk("hold_chan", bus.m_chan, hold_c);
            end
            hold   = bus.m_valid && !bus.m_ready;
            hold_d = bus.m_data;
            hold_c = int'(bus.m_chan);
            if (bus.m_valid && bus.m_ready) begin
                if (exp_d.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d expected nothing", bus.m_data);
                end else begin
                    ed = exp_d.pop_front();
                    ec = exp_c.pop_front();
                    chk("out_data", bus.m_data, ed);
                    chk("out_chan", bus.m_chan, ec);
                    chk("out_last", bus.m_last, (ec == 1) ? 1 : 0);
                    got_d.push_back(bus.m_data);
                    got_c.push_back(int'(bus.m_chan));
                end
            end
            if (bus.s_valid && bus.s_ready) begin
                if (mch == 0) begin
                    sh_opt = options;
                    sh_g   = gain;
                    sh_t   = threshold;
                end
                exp_d.push_back(model(bus.s_data, sh_opt, sh_g, sh_t, en[mch]));
                exp_c.push_back(mch);
                mch = (mch + 1) % 2;
            end
        end
    end

    task automatic send(input longint d);
        logic acc;
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d[DW-1:0];
        do begin
            @(negedge clk_48);
            acc = bus.s_ready;
            @(posedge clk_48);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got not accepted expected accepted");
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_d.size() != 0 && n < 60) begin
            @(posedge clk_48);
            n++;
        end
        #1;
        chk("drain_pending", exp_d.size(), 0);
    endtask

    task automatic check_got(input string nm, input int i, input longint v);
        if (i < got_d.size()) chk(nm, got_d[i], v);
        else chk({nm, "_missing"}, got_d.size(), i + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint first_d;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        options     = 4'b0000;
        en          = 2'b11;
        gain        = 8'h10;
        threshold   = '0;
        rst         = 1'b1;

        repeat (3) @(posedge clk_48);
        #1;
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_chan", bus.m_chan, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_s_ready", bus.s_ready, 0);
        rst = 1'b0;

        // Pin the reference model to hand-computed values
        chk("model_fold_pos", model(7000, 4'b0010, 16, 5000, 1'b1), 3000);
        chk("model_asym", model(-4000, 4'b0100, 16, 5000, 1'b1), -2500);
        chk("model_crush_neg", model(-1, 4'b0001, 16, 0, 1'b1), -256);
        chk("model_hard_gain2", model(4000, 4'b1000, 32, 5000, 1'b1), 5000);

        // Bypass with latency probe
        got_d.delete(); got_c.delete();
        send(1000);
        @(posedge clk_48); #1;
        chk("lat_cycle2_invalid", bus.m_valid, 0);
        @(posedge clk_48); #1;
        chk("lat_cycle3_valid", bus.m_valid, 1);
        chk("lat_cycle3_data", bus.m_data, 1000);
        send(-1000);
        drain();
        check_got("byp_ch0", 0, 1000);
        check_got("byp_ch1", 1, -1000);
        if (got_c.size() > 1) chk("byp_chan1", got_c[1], 1);

        // Hard clip, gain 2.0
        got_d.delete(); got_c.delete();
        options = 4'b1000; threshold = 23'd5000; gain = 8'h20;
        send(2000); send(4000); send(-4000); send(0);
        drain();
        check_got("hard_0", 0, 4000);
        check_got("hard_1", 1, 5000);
        check_got("hard_2", 2, -5000);
        check_got("hard_3", 3, 0);

        // Asymmetric, then clip modes with zero threshold
        got_d.delete(); got_c.delete();
        options = 4'b0100; gain = 8'h10;
        send(-4000); send(6000);
        threshold = '0;
        send(777); send(-777);
        drain();
        check_got("asym_neg", 0, -2500);
        check_got("asym_pos", 1, 5000);
        check_got("asym_t0_pos", 2, 0);
        check_got("asym_t0_neg", 3, 0);

        // Fold-back, including a saturated full-scale pair
        got_d.delete(); got_c.delete();
        options = 4'b0010; threshold = 23'd5000; gain = 8'h10;
        send(7000); send(-6000);
        gain = 8'hFF;
        send(8388607); send(-8388608);
        drain();
        check_got("fold_pos", 0, 3000);
        check_got("fold_neg", 1, -4000);
        check_got("fold_sat_pos", 2, -8378607);
        check_got("fold_sat_neg", 3, 8378608);

        // Crush with ch1 disabled
        got_d.delete(); got_c.delete();
        options = 4'b0001; gain = 8'h10; en = 2'b01;
        send(64'h12FF); send(64'h12FF); send(-1); send(-5);
        drain();
        check_got("crush_ch0", 0, 64'h1200);
        check_got("crush_ch1_raw", 1, 64'h12FF);
        check_got("crush_neg", 2, -256);
        check_got("crush_ch1_raw_neg", 3, -5);

        // Mode change mid-frame only lands at the next ch0
        got_d.delete(); got_c.delete();
        en = 2'b11; options = 4'b1000; threshold = 23'd5000;
        send(6000);
        options = 4'b0100;
        send(-4000); send(-4000); send(-4000);
        drain();
        check_got("mchg_ch0_hard", 0, 5000);
        check_got("mchg_ch1_still_hard", 1, -4000);
        check_got("mchg_next_ch0_asym", 2, -2500);
        check_got("mchg_next_ch1_asym", 3, -2500);

        // Backpressure with continuous input
        got_d.delete(); got_c.delete();
        options = 4'b0000;
        bus.m_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(100 * (i + 1));
            end
            begin
                repeat (4) @(negedge clk_48);
                chk("bp_s_ready_low", bus.s_ready, 0);
                chk("bp_m_valid", bus.m_valid, 1);
                first_d = bus.m_data;
                repeat (5) begin
                    @(negedge clk_48);
                    chk("bp_stable", bus.m_data, first_d);
                end
                @(posedge clk_48); #1;
                bus.m_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", got_d.size(), 8);
        check_got("bp_first", 0, 100);
        check_got("bp_last", 7, 800);

        // Reset mid-frame
        send(11); send(22); send(33);
        chk("rst_pre_m_valid", bus.m_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_m_valid", bus.m_valid, 0);
        chk("rst_async_s_ready", bus.s_ready, 0);
        chk("rst_async_m_data", bus.m_data, 0);
        repeat (2) @(posedge clk_48);
        #1;
        rst = 1'b0;
        got_d.delete(); got_c.delete();
        send(500); send(600);
        drain();
        check_got("post_rst_0", 0, 500);
        check_got("post_rst_1", 1, 600);
        if (got_c.size() > 0) chk("post_rst_chan0", got_c[0], 0);
        else chk("post_rst_chan0_missing", got_c.size(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
